pixel_combinator: RTL and testbench

PIXEL_COMBINATOR -- requirements
Module: pixel_combinator

---
 rtl/pixel_combinator.sv | 167 ++++++++++++++++
 tb/tb_pixel_combinator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_combinator.sv
// pixel_combinator
//   Pulls pixels out of NUM_QUEUES engine queues in strict raster order.
//   Each cycle in SEARCH every queue head is compared against the expected
//   (x,y); the lowest-index match supplies the colour and every matching
//   queue is popped so duplicates are discarded. If no queue produces the
//   pixel within TIMEOUT cycles a black pixel is emitted instead and
//   fill_count is bumped.
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   start                 begin a frame (sampled only in IDLE)
//   q_valid/q_xpixel/q_ypixel/q_colour   per-queue head, packed by slice
//   q_pop                 one-cycle pop strobe per queue
//   xpixel_check/ypixel_check            expected coordinates
//   out_valid/out_ready/out_colour/out_sof/out_eol   pixel stream
//   busy, done, fill_count                frame status

// Per-queue head comparator: full-width match against the expected pixel.
module pixel_combinator_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  input  logic [DATA_WIDTH-1:0] ex_x_i,
  input  logic [DATA_WIDTH-1:0] ex_y_i,
  output logic                  match_o
);
  assign match_o = vld_i && (x_i == ex_x_i) && (y_i == ex_y_i);
endmodule

module pixel_combinator #(
  parameter int NUM_QUEUES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RBG_SIZE   = 24,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int TIMEOUT    = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_QUEUES-1:0]          q_valid,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_xpixel,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_ypixel,
  input  logic [NUM_QUEUES*RBG_SIZE-1:0] q_colour,
  output logic [NUM_QUEUES-1:0]          q_pop,
  output logic [DATA_WIDTH-1:0]          xpixel_check,
  output logic [DATA_WIDTH-1:0]          ypixel_check,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RBG_SIZE-1:0]            out_colour,
  output logic                           out_sof,
  output logic                           out_eol,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    fill_count
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, EMIT, FINISH} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] x_q, y_q;
  logic [TW-1:0]         stall_q;
  logic [15:0]           fill_q;
  logic [RBG_SIZE-1:0]   colour_q;
  logic                  valid_q, sof_q, eol_q, busy_q, done_q;

  logic [NUM_QUEUES-1:0] match;
  logic [RBG_SIZE-1:0]   sel_col;
  logic                  any_match, last_x, last_y, at_origin;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_lane
    pixel_combinator_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .vld_i   (q_valid[i]),
      .x_i     (q_xpixel[i*DATA_WIDTH +: DATA_WIDTH]),
      .y_i     (q_ypixel[i*DATA_WIDTH +: DATA_WIDTH]),
      .ex_x_i  (x_q),
      .ex_y_i  (y_q),
      .match_o (match[i])
    );
  end

  // Walk from the top down so the lowest-index match wins.
  always_comb begin
    sel_col = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--)
      if (match[i]) sel_col = q_colour[i*RBG_SIZE +: RBG_SIZE];
  end

  assign any_match = |match;
  assign last_x    = (x_q == DATA_WIDTH'(IMG_WIDTH - 1));
  assign last_y    = (y_q == DATA_WIDTH'(IMG_HEIGHT - 1));
  assign at_origin = (x_q == '0) && (y_q == '0);

  // Pop is combinational so the matching queue is released in the same
  // cycle the match is seen; only SEARCH ever pops.
  assign q_pop        = (state_q == SEARCH) ? match : '0;
  assign xpixel_check = x_q;
  assign ypixel_check = y_q;
  assign out_valid    = valid_q;
  assign out_colour   = colour_q;
  assign out_sof      = sof_q;
  assign out_eol      = eol_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fill_count   = fill_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      stall_q  <= '0;
      fill_q   <= '0;
      colour_q <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= SEARCH;
          x_q     <= '0;
          y_q     <= '0;
          fill_q  <= '0;
          busy_q  <= 1'b1;
        end
        SEARCH: begin
          if (any_match || (stall_q == TW'(TIMEOUT - 1))) begin
            // Either a real pixel or a black fill after the stall limit.
            colour_q <= any_match ? sel_col : '0;
            sof_q    <= at_origin;
            eol_q    <= last_x;
            valid_q  <= 1'b1;
            stall_q  <= '0;
            state_q  <= EMIT;
            if (!any_match && (fill_q != 16'hFFFF)) fill_q <= fill_q + 16'd1;
          end else begin
            stall_q <= stall_q + TW'(1);
          end
        end
        EMIT: if (out_ready) begin
          valid_q <= 1'b0;
          if (last_x) begin
            x_q <= '0;
            y_q <= y_q + DATA_WIDTH'(1);
          end else begin
            x_q <= x_q + DATA_WIDTH'(1);
          end
          if (last_x && last_y) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= SEARCH;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_combinator.sv
module tb_pixel_combinator;
  localparam int NQ = 4, DW = 16, CW = 24, W = 4, H = 2, TO = 8, NPIX = W * H;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [NQ-1:0]    q_valid = '0;
  logic [NQ-1:0]    q_pop;
  logic [NQ*DW-1:0] q_xpixel = '0, q_ypixel = '0;
  logic [NQ*CW-1:0] q_colour = '0;
  logic [DW-1:0]    xpixel_check, ypixel_check;
  logic             out_valid, out_sof, out_eol, busy, done;
  logic [CW-1:0]    out_colour;
  logic [15:0]      fill_count;

  pixel_combinator #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW), .RBG_SIZE(CW),
                     .IMG_WIDTH(W), .IMG_HEIGHT(H), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .q_valid(q_valid),
    .q_xpixel(q_xpixel), .q_ypixel(q_ypixel), .q_colour(q_colour),
    .q_pop(q_pop), .xpixel_check(xpixel_check), .ypixel_check(ypixel_check),
    .out_valid(out_valid), .out_ready(out_ready), .out_colour(out_colour),
    .out_sof(out_sof), .out_eol(out_eol), .busy(busy), .done(done),
    .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] colour;
    logic          sof;
    logic          eol;
    logic          fill;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            ent_pix [NQ][NPIX];
  logic [CW-1:0] ent_col [NQ][NPIX];
  int            cnt [NQ];
  int            hd  [NQ];
  int            checks = 0, errors = 0;
  int            pix = 0, scnt = 0, done_cnt = 0, exp_fill = 0, hold = 0;
  bit            mon_en = 1'b0, popped = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [CW-1:0] prev_col = '0;
  logic [NQ-1:0] pop_rec = '0, mon_mask;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (pixel %0d, t=%0t)", name, act, exp, pix, $time);
    end
  endtask

  // Reference model: each queue holds its pixels in raster order, so when
  // pixel p is due every queue that owns p has it at its head. The output
  // colour is the lowest-index owner's colour, or black with a fill.
  task automatic build(input int mode);
    logic [NQ-1:0] has;
    logic [CW-1:0] col;
    bit            found;
    exp_t          e;
    sb.delete();
    exp_fill = 0;
    for (int i = 0; i < NQ; i++) begin cnt[i] = 0; hd[i] = 0; end
    for (int p = 0; p < NPIX; p++) begin
      has = '0;
      case (mode)
        0: for (int i = 0; i < NQ; i++) has[i] = ($urandom_range(0, 2) == 0);
        1: has[0] = 1'b1;
        2: has[p % NQ] = 1'b1;
        3: if (p == 0) has = 4'b0110; else has[0] = 1'b1;
        default: if (p != 1) has[0] = 1'b1;
      endcase
      e.colour = '0;
      e.sof = (p == 0);
      e.eol = ((p % W) == W - 1);
      e.fill = (has == '0);
      found = 1'b0;
      for (int i = 0; i < NQ; i++) begin
        if (has[i]) begin
          if (mode == 3 && p == 0) col = (i == 1) ? 24'h00FF00 : 24'h0000FF;
          else col = CW'($urandom);
          ent_pix[i][cnt[i]] = p;
          ent_col[i][cnt[i]] = col;
          cnt[i]++;
          if (!found) begin e.colour = col; found = 1'b1; end
        end
      end
      if (e.fill) exp_fill++;
      sb.push_back(e);
    end
  endtask

  // Invalid or scrambled heads deliberately carry the current pixel's
  // coordinates so that an ungated compare would be caught.
  task automatic drive_heads(input bit scramble);
    for (int i = 0; i < NQ; i++) begin
      if (!scramble && hd[i] < cnt[i]) begin
        q_valid[i] = 1'b1;
        q_xpixel[i*DW +: DW] = DW'(ent_pix[i][hd[i]] % W);
        q_ypixel[i*DW +: DW] = DW'(ent_pix[i][hd[i]] / W);
        q_colour[i*CW +: CW] = ent_col[i][hd[i]];
      end else begin
        q_valid[i] = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
        q_xpixel[i*DW +: DW] = DW'(pix % W);
        q_ypixel[i*DW +: DW] = DW'(pix / W);
        q_colour[i*CW +: CW] = CW'($urandom);
      end
    end
  endtask

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (reset && mon_en) begin
      if (busy) begin
        chk("xcheck", 64'(xpixel_check), 64'(pix % W));
        chk("ycheck", 64'(ypixel_check), 64'(pix / W));
      end
      if (q_pop != '0) begin
        mon_mask = '0;
        for (int i = 0; i < NQ; i++)
          if (hd[i] < cnt[i] && ent_pix[i][hd[i]] == pix) mon_mask[i] = 1'b1;
        chk("pop_mask", 64'(q_pop), 64'(mon_mask));
        chk("pop_in_emit", 64'(out_valid), 64'd0);
        chk("pop_twice", 64'(popped), 64'd0);
        popped = 1'b1;
        pop_rec = q_pop;
      end
      if (busy && !out_valid) scnt++;
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_colour", 64'(out_colour), 64'(prev_col));
      end
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) chk("unexpected_pixel", 64'(sb.size()), 64'd1);
        else chk("search_cycles", 64'(scnt), sb[0].fill ? 64'(TO) : 64'd1);
        scnt = 0;
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("colour", 64'(out_colour), 64'(mon_e.colour));
        chk("sof", 64'(out_sof), 64'(mon_e.sof));
        chk("eol", 64'(out_eol), 64'(mon_e.eol));
        chk("popped_for_pixel", 64'(popped), 64'(!mon_e.fill));
        pix++;
        popped = 1'b0;
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("fill_count", 64'(fill_count), 64'(exp_fill));
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_col   = out_colour;
    end
  end

  // rdy_mode: 0 always ready, 1 random ready + scrambled heads in EMIT,
  // 2 five stalled cycles on pixel 2. abort_at >= 0 stops at that pixel.
  task automatic run_frame(input int mode, input int rdy_mode, input int abort_at);
    bit fin;
    build(mode);
    pix = 0; scnt = 0; done_cnt = 0; popped = 1'b0; pop_rec = '0;
    prev_valid = 1'b0; prev_ready = 1'b0; hold = 0; fin = 1'b0;
    drive_heads(1'b0);
    out_ready = 1'b1;
    start = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NQ; i++) if (pop_rec[i]) hd[i]++;
      pop_rec = '0;
      start = (pix >= 2 && pix <= 4);  // must be ignored mid-frame
      if (abort_at >= 0 && pix == abort_at) begin fin = 1'b1; break; end
      if (done_cnt > 0) begin fin = 1'b1; break; end
      drive_heads(rdy_mode == 1 && out_valid && $urandom_range(0, 1) == 1);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (pix == 2 && out_valid && hold < 5) begin out_ready = 1'b0; hold++; end
          else out_ready = 1'b1;
        end
      endcase
    end
    chk("frame_finished", 64'(fin), 64'd1);
    start = 1'b0;
    if (abort_at < 0) begin
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", 64'(done_cnt), 64'd1);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      for (int i = 0; i < NQ; i++) chk("queue_drained", 64'(hd[i]), 64'(cnt[i]));
    end
  endtask

  task automatic check_reset();
    chk("rst_pop", 64'(q_pop), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_colour", 64'(out_colour), 64'd0);
    chk("rst_sof", 64'(out_sof), 64'd0);
    chk("rst_eol", 64'(out_eol), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fill", 64'(fill_count), 64'd0);
    chk("rst_x", 64'(xpixel_check), 64'd0);
    chk("rst_y", 64'(ypixel_check), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", 64'(busy), 64'd0);

    run_frame(1, 0, -1);  // in-order, single queue
    run_frame(2, 0, -1);  // interleaved across queues
    run_frame(1, 2, -1);  // backpressure on pixel 2
    run_frame(3, 0, -1);  // duplicate (0,0) in queues 1 and 2
    run_frame(4, 0, -1);  // (1,0) missing -> fill
    for (int k = 0; k < 8; k++) run_frame(0, 1, -1);

    // Mid-frame reset while pixel (2,1) is being searched.
    run_frame(1, 0, 6);
    #2 reset = 1'b0;
    #1;
    mon_en = 1'b0;
    check_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("no_restart", 64'(busy), 64'd0);
    end
    run_frame(0, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
